vec_pack: RTL and testbench

VEC_PACK -- requirements
Module: vec_pack

---
 rtl/ddnet_pkg.sv | 15 +
 rtl/vec_pack_bank.sv | 44 ++++
 rtl/vec_pack.sv | 115 +++++++++++
 tb/tb_vec_pack.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddnet_pkg.sv
// Shared constants for the pack and dot-product stages: element format 1.4.11,
// vector geometry, and the per-bank occupancy encoding.
package ddnet_pkg;

    localparam int ELEM_W    = 16;
    localparam int N_ELEM    = 16;
    localparam int VEC_W     = ELEM_W * N_ELEM;
    localparam int FRAC_BITS = 11;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

endpackage

// File: rtl/vec_pack_bank.sv
// One A/B lane-register pair. Lane wr_idx takes the incoming element;
// with zero_fill set, every lane above wr_idx is cleared on the same write.
module vec_pack_bank #(
    parameter int ELEM_W = ddnet_pkg::ELEM_W,
    parameter int N_ELEM = ddnet_pkg::N_ELEM,
    parameter int CW     = $clog2(ddnet_pkg::N_ELEM + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       zero_fill,
    input  logic [CW-1:0]              wr_idx,
    input  logic [ELEM_W-1:0]          wr_a,
    input  logic [ELEM_W-1:0]          wr_b,
    output logic [ELEM_W*N_ELEM-1:0]   vec_a,
    output logic [ELEM_W*N_ELEM-1:0]   vec_b
);

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_lane
            logic [ELEM_W-1:0] a_reg;
            logic [ELEM_W-1:0] b_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (wr_en) begin
                    if (wr_idx == CW'(gi)) begin
                        a_reg <= wr_a;
                        b_reg <= wr_b;
                    end else if (zero_fill && (wr_idx < CW'(gi))) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end
                end
            end

            assign vec_a[gi*ELEM_W +: ELEM_W] = a_reg;
            assign vec_b[gi*ELEM_W +: ELEM_W] = b_reg;
        end
    endgenerate

endmodule

// File: rtl/vec_pack.sv
// Packs streamed A/B element pairs into full-width vectors for the dot-product stage.
// Define VEC_PACK_DBUF_EN for ping-pong banks; otherwise a single bank is used.
module vec_pack #(
    parameter int ELEM_W = ddnet_pkg::ELEM_W,
    parameter int N_ELEM = ddnet_pkg::N_ELEM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEM_W-1:0]          in_a,
    input  logic [ELEM_W-1:0]          in_b,
    input  logic                       in_last,
    output logic [ELEM_W*N_ELEM-1:0]   vec_a,
    output logic [ELEM_W*N_ELEM-1:0]   vec_b,
    output logic                       vec_valid,
    input  logic                       vec_ready
);

    import ddnet_pkg::*;

    localparam int CW = $clog2(N_ELEM + 1);
`ifdef VEC_PACK_DBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    bank_state_t               state_reg  [2];
    bank_state_t               state_next [2];
    logic                      wr_ptr_reg, wr_ptr_next;
    logic                      rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]             fill_cnt_reg, fill_cnt_next;
    logic                      vec_valid_reg, vec_valid_next;
    logic                      accept, complete, handshake;
    logic [ELEM_W*N_ELEM-1:0]  bank_a [2];
    logic [ELEM_W*N_ELEM-1:0]  bank_b [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg[0]  <= BANK_FREE;
            state_reg[1]  <= BANK_FREE;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            fill_cnt_reg  <= '0;
            vec_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            fill_cnt_reg  <= fill_cnt_next;
            vec_valid_reg <= vec_valid_next;
        end
    end

    // A release and a completion never target the same bank: one needs it full, the other free.
    always_comb begin
        in_ready  = (state_reg[wr_ptr_reg] == BANK_FREE);
        accept    = in_valid && in_ready;
        complete  = accept && (in_last || (fill_cnt_reg == CW'(N_ELEM - 1)));
        handshake = vec_valid_reg && vec_ready;

        state_next = state_reg;
        if (handshake)
            state_next[rd_ptr_reg] = BANK_FREE;
        if (complete)
            state_next[wr_ptr_reg] = BANK_FULL;

        if (complete)
            fill_cnt_next = '0;
        else if (accept)
            fill_cnt_next = fill_cnt_reg + CW'(1);
        else
            fill_cnt_next = fill_cnt_reg;

`ifdef VEC_PACK_DBUF_EN
        wr_ptr_next = wr_ptr_reg ^ complete;
        rd_ptr_next = rd_ptr_reg ^ handshake;
`else
        wr_ptr_next = 1'b0;
        rd_ptr_next = 1'b0;
`endif
        vec_valid_next = (state_next[rd_ptr_next] == BANK_FULL);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            if (gi < NBANK) begin : g_inst
                vec_pack_bank #(
                    .ELEM_W (ELEM_W),
                    .N_ELEM (N_ELEM),
                    .CW     (CW)
                ) u_bank (
                    .clk       (clk),
                    .rst       (rst),
                    .wr_en     (accept && (wr_ptr_reg == 1'(gi))),
                    .zero_fill (in_last),
                    .wr_idx    (fill_cnt_reg),
                    .wr_a      (in_a),
                    .wr_b      (in_b),
                    .vec_a     (bank_a[gi]),
                    .vec_b     (bank_b[gi])
                );
            end else begin : g_none
                assign bank_a[gi] = '0;
                assign bank_b[gi] = '0;
            end
        end
    endgenerate

    assign vec_a     = bank_a[rd_ptr_reg];
    assign vec_b     = bank_b[rd_ptr_reg];
    assign vec_valid = vec_valid_reg;

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack with a vector scoreboard; expectations adapt to
// whether VEC_PACK_DBUF_EN is defined.
module tb_vec_pack;

    localparam int EW = ddnet_pkg::ELEM_W;
    localparam int NE = ddnet_pkg::N_ELEM;
    localparam int VW = ddnet_pkg::VEC_W;
`ifdef VEC_PACK_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    typedef struct {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        int            len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          vec_ready = 1'b0;
    logic [EW-1:0] in_a = '0;
    logic [EW-1:0] in_b = '0;
    logic          in_ready;
    logic          vec_valid;
    logic [VW-1:0] vec_a;
    logic [VW-1:0] vec_b;

    int checks = 0;
    int failures = 0;
    int out_vecs = 0;
    int out_elems = 0;

    exp_t          sb[$];
    logic [EW-1:0] m_a [NE];
    logic [EW-1:0] m_b [NE];
    int            m_idx = 0;

    vec_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_idx = 0;
        for (int i = 0; i < NE; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
    endtask

    task automatic model_accept();
        exp_t e;
        m_a[m_idx] = in_a;
        m_b[m_idx] = in_b;
        if (in_last || m_idx == NE - 1) begin
            for (int i = 0; i < NE; i++) begin
                e.a[i*EW +: EW] = m_a[i];
                e.b[i*EW +: EW] = m_b[i];
            end
            e.len = m_idx + 1;
            sb.push_back(e);
            model_clear();
        end else begin
            m_idx++;
        end
    endtask

    // Called #1 after an edge with inputs set: settles bookkeeping for the next edge.
    task automatic step();
        exp_t e;
        if (vec_valid === 1'b1 && vec_ready === 1'b1) begin
            chk("sb_nonempty", VW'(sb.size() != 0), VW'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("vec_a", vec_a, e.a);
                chk("vec_b", vec_b, e.b);
                out_vecs++;
                out_elems += e.len;
                $display("t=%0t vector %0d out len=%0d a=%0h", $time, out_vecs, e.len, vec_a);
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1 && rst === 1'b0)
            model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [EW-1:0] a, input logic [EW-1:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        while (in_ready !== 1'b1 && n <= 200) begin
            step();
            n++;
        end
        chk("send_timeout", VW'(n <= 200), VW'(1));
        step();
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        vec_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", VW'(sb.size()), VW'(0));
    endtask

    initial begin
        int            acc;
        int            unstable;
        int            bad;
        int            base_vecs;
        int            base_elems;
        logic          cap;
        logic [VW-1:0] cap_a;
        logic [VW-1:0] cap_b;

        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec_valid", VW'(vec_valid), VW'(0));
        chk("rst_vec_a", vec_a, VW'(0));
        chk("rst_vec_b", vec_b, VW'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", VW'(in_ready), VW'(1));

        // Full vector, ramp on A, constant 1.0 on B
        vec_ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            if (k == NE - 1)
                chk("ramp_valid_before", VW'(vec_valid), VW'(0));
            send(EW'(k * 16'h0800), 16'h0800, 1'b0);
        end
        in_valid = 1'b0;
        chk("ramp_valid_rise", VW'(vec_valid), VW'(1));
        chk("ramp_lane15", VW'(vec_a[15*EW +: EW]), VW'(16'h7800));
        step();
        chk("ramp_valid_one_cycle", VW'(vec_valid), VW'(0));
        chk("ramp_out_vecs", VW'(out_vecs), VW'(1));

        // Short vector ended by in_last on element 5
        for (int k = 0; k < 6; k++)
            send(16'h1000, 16'h1000, k == 5);
        in_valid = 1'b0;
        chk("short_valid", VW'(vec_valid), VW'(1));
        chk("short_lane6_a", VW'(vec_a[6*EW +: EW]), VW'(0));
        step();
        chk("short_out_elems", VW'(out_elems), VW'(NE + 6));

        // Downstream stalled for 40 cycles with continuous input
        vec_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        unstable = 0;
        cap = 1'b0;
        cap_a = '0;
        cap_b = '0;
        for (int i = 0; i < 40; i++) begin
            in_a = EW'(16'h0100 + i);
            in_b = EW'(16'hFF00 - i);
            if (in_ready === 1'b1)
                acc++;
            if (vec_valid === 1'b1) begin
                if (!cap) begin
                    cap = 1'b1;
                    cap_a = vec_a;
                    cap_b = vec_b;
                end else if (vec_a !== cap_a || vec_b !== cap_b) begin
                    unstable++;
                end
            end else if (cap) begin
                unstable++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("stall_accepts", VW'(acc), VW'(DBUF ? 2 * NE : NE));
        chk("stall_in_ready", VW'(in_ready), VW'(0));
        chk("stall_valid_held", VW'(vec_valid), VW'(1));
        chk("stall_stable", VW'(unstable), VW'(0));
        drain();

        // Completion and handshake on the same edge (DBUF); plain streaming otherwise
        base_vecs = out_vecs;
        base_elems = out_elems;
        for (int k = 0; k < 2 * NE; k++) begin
            vec_ready = DBUF ? (k == 2 * NE - 1) : 1'b1;
            send(EW'(16'h0040 * k), EW'(16'h2000 - k), 1'b0);
        end
        in_valid = 1'b0;
        chk("same_edge_valid", VW'(vec_valid), VW'(1));
        chk("same_edge_first_out", VW'(out_vecs - base_vecs), VW'(1));
        vec_ready = 1'b1;
        step();
        chk("same_edge_vecs", VW'(out_vecs - base_vecs), VW'(2));
        chk("same_edge_elems", VW'(out_elems - base_elems), VW'(2 * NE));

        // Reset after 7 accepts discards the partial bank
        for (int k = 0; k < 7; k++)
            send(16'h0555, 16'h0AAA, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", VW'(vec_valid), VW'(0));
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (vec_valid !== 1'b0)
                bad++;
            step();
        end
        chk("midrst_no_valid", VW'(bad), VW'(0));
        for (int k = 0; k < NE; k++)
            send(EW'(16'h0011 * (k + 1)), EW'(16'h0F00 + k), 1'b0);
        in_valid = 1'b0;
        chk("midrst_lane0", VW'(vec_a[EW-1:0]), VW'(16'h0011));
        step();

        // Negative patterns pass through unchanged
        for (int k = 0; k < NE; k++)
            send(16'hF800, 16'h8000, 1'b0);
        in_valid = 1'b0;
        chk("neg_lane0_a", VW'(vec_a[EW-1:0]), VW'(16'hF800));
        chk("neg_lane15_b", VW'(vec_b[15*EW +: EW]), VW'(16'h8000));
        drain();

        step();
        chk("end_in_ready", VW'(in_ready), VW'(1));
        chk("end_no_valid", VW'(vec_valid), VW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
